// File: rtl/iob_cache_line_fill_if.sv
// Front-end request/response, AXI read-channel and data-memory write signals of
// the cache line-fill block, grouped so both sides bind to one bundle.
interface iob_cache_line_fill_if #(
  parameter int ADDR_W        = 32,
  parameter int DATA_W        = 32,
  parameter int BE_DATA_W     = 64,
  parameter int WORD_OFFSET_W = 3
);
  localparam int BE_NBYTES_W = $clog2(BE_DATA_W / 8);
  localparam int LINE2BE_W   = WORD_OFFSET_W - $clog2(BE_DATA_W / DATA_W);
  localparam int LINE_W      = DATA_W * (2 ** WORD_OFFSET_W);
  localparam int LA_W        = ADDR_W - BE_NBYTES_W - LINE2BE_W;

  // Handshakes: a request is taken on a clock edge where req_valid_i and
  // req_ready_o are both 1; rvalid_o, fill_err_o and line_we_o are single-cycle
  // strobes with no back-pressure; replace_valid_o is held until replace_i rises,
  // and read_valid_i beats are only taken while the read channel is busy.
  logic                 req_valid_i;
  logic [ADDR_W-1:0]    req_addr_i;
  logic                 req_ready_o;
  logic                 rvalid_o;
  logic [DATA_W-1:0]    rdata_o;
  logic                 fill_err_o;
  logic                 replace_valid_o;
  logic [LA_W-1:0]      replace_addr_o;
  logic                 replace_i;
  logic                 read_valid_i;
  logic [LINE2BE_W-1:0] read_addr_i;
  logic [BE_DATA_W-1:0] read_rdata_i;
  logic                 line_we_o;
  logic [LA_W-1:0]      line_addr_o;
  logic [LINE_W-1:0]    line_data_o;

  modport master (
    output req_valid_i, req_addr_i, replace_i, read_valid_i, read_addr_i, read_rdata_i,
    input  req_ready_o, rvalid_o, rdata_o, fill_err_o, replace_valid_o, replace_addr_o,
           line_we_o, line_addr_o, line_data_o
  );

  modport slave (
    input  req_valid_i, req_addr_i, replace_i, read_valid_i, read_addr_i, read_rdata_i,
    output req_ready_o, rvalid_o, rdata_o, fill_err_o, replace_valid_o, replace_addr_o,
           line_we_o, line_addr_o, line_data_o
  );
endinterface

// File: rtl/iob_cache_line_fill.sv
// Cache miss line fill: requests a line from the read channel, assembles the
// beats into a line buffer, writes the line to data memory, then returns the word.
module iob_cache_line_fill #(
  parameter int ADDR_W        = 32,
  parameter int DATA_W        = 32,
  parameter int BE_DATA_W     = 64,
  parameter int WORD_OFFSET_W = 3
) (
  input  logic                 clk_i,
  input  logic                 arst_n_i,
  iob_cache_line_fill_if.slave bus,
  output logic [2:0]           state_dbg_o
);
  localparam int NBYTES_W    = $clog2(DATA_W / 8);
  localparam int BE_NBYTES_W = $clog2(BE_DATA_W / 8);
  localparam int LINE2BE_W   = WORD_OFFSET_W - $clog2(BE_DATA_W / DATA_W);
  localparam int LINE_W      = DATA_W * (2 ** WORD_OFFSET_W);
  localparam int LA_W        = ADDR_W - BE_NBYTES_W - LINE2BE_W;
  localparam logic [LINE2BE_W:0] BEATS = {1'b1, {LINE2BE_W{1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_FILL  = 3'd2,
    S_WRITE = 3'd3,
    S_RESP  = 3'd4
  } state_t;

  state_t                 state_q, state_d;
  logic [LA_W-1:0]        la_q, la_d;
  logic [WORD_OFFSET_W-1:0] word_q, word_d;
  logic [LINE2BE_W:0]     cnt_q, cnt_d;
  logic [LINE_W-1:0]      buf_q, buf_d;
  logic                   replace_valid_q, replace_valid_d;
  logic                   line_we_q, line_we_d;
  logic                   rvalid_q, rvalid_d;
  logic                   fill_err_q, fill_err_d;
  logic [DATA_W-1:0]      rdata_q, rdata_d;

  always_comb begin
    state_d = state_q;
    la_d    = la_q;
    word_d  = word_q;
    cnt_d   = cnt_q;
    buf_d   = buf_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.req_valid_i) begin
          la_d    = bus.req_addr_i[ADDR_W-1 -: LA_W];
          word_d  = bus.req_addr_i[WORD_OFFSET_W+NBYTES_W-1:NBYTES_W];
          cnt_d   = '0;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (bus.replace_i) state_d = S_FILL;
      end
      S_FILL: begin
        // A beat 0 restarts the count so a retried burst is judged on its own.
        if (bus.read_valid_i) begin
          buf_d[BE_DATA_W*bus.read_addr_i +: BE_DATA_W] = bus.read_rdata_i;
          if (bus.read_addr_i == '0) cnt_d = {{LINE2BE_W{1'b0}}, 1'b1};
          else if (cnt_q != BEATS)   cnt_d = cnt_q + 1'b1;
        end
        if (!bus.replace_i) state_d = S_WRITE;
      end
      S_WRITE: state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state; buffer and count are stable in WRITE.
  always_comb begin
    replace_valid_d = (state_d == S_REQ);
    line_we_d       = (state_d == S_WRITE);
    rvalid_d        = (state_d == S_RESP);
    fill_err_d      = (state_d == S_RESP) && (cnt_q != BEATS);
    rdata_d         = (state_d == S_RESP) ? buf_q[DATA_W*word_q +: DATA_W] : '0;
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_q         <= S_IDLE;
      la_q            <= '0;
      word_q          <= '0;
      cnt_q           <= '0;
      buf_q           <= '0;
      replace_valid_q <= 1'b0;
      line_we_q       <= 1'b0;
      rvalid_q        <= 1'b0;
      fill_err_q      <= 1'b0;
      rdata_q         <= '0;
    end else begin
      state_q         <= state_d;
      la_q            <= la_d;
      word_q          <= word_d;
      cnt_q           <= cnt_d;
      buf_q           <= buf_d;
      replace_valid_q <= replace_valid_d;
      line_we_q       <= line_we_d;
      rvalid_q        <= rvalid_d;
      fill_err_q      <= fill_err_d;
      rdata_q         <= rdata_d;
    end
  end

  assign bus.req_ready_o     = (state_q == S_IDLE);
  assign bus.replace_valid_o = replace_valid_q;
  assign bus.replace_addr_o  = la_q;
  assign bus.line_we_o       = line_we_q;
  assign bus.line_addr_o     = la_q;
  assign bus.line_data_o     = buf_q;
  assign bus.rvalid_o        = rvalid_q;
  assign bus.rdata_o         = rdata_q;
  assign bus.fill_err_o      = fill_err_q;
  assign state_dbg_o         = state_q;
endmodule
